frame_pixel_fetch: RTL and testbench

- Display-side consumer of the 450x450 3-bit frame buffer.
- Converts the VGA controller's DrawX/DrawY scan position into frame-buffer read addresses without a multiplier, and drives them to the buffer.
- Realigns the returned 3-bit colour index with the scan and maps it through a fixed 8-entry palette to 24-bit RGB.
- Sits between the VGA controller and the VGA DAC outputs; one pixel per Clk.

---
 rtl/frame_pixel_fetch_if.sv | 28 ++
 rtl/frame_pixel_fetch.sv | 109 ++++++++++
 tb/tb_frame_pixel_fetch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/frame_pixel_fetch_if.sv
// Display-side frame-buffer fetch bus.
// Groups the VGA scan position/blanking, the frame-buffer read port and the RGB outputs.
//   DrawX, DrawY  : scan column/row from the VGA controller
//   blank         : active-low blanking (0 = blanked)
//   read_address  : frame-buffer read address (buffer has a 1-cycle registered read)
//   fb_data       : colour index returned by the buffer one clock after read_address
//   VGA_R/G/B     : 8-bit colour channels towards the DAC
// master: the environment (VGA controller + buffer + DAC); slave: the fetch block.
interface frame_pixel_fetch_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [17:0] read_address;
  logic [2:0]  fb_data;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  modport master (
    output DrawX, DrawY, blank, fb_data,
    input  read_address, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    input  DrawX, DrawY, blank, fb_data,
    output read_address, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/frame_pixel_fetch.sv
// Frame-buffer pixel fetch for a FbW x FbH, 3-bit-per-pixel frame buffer.
// Turns the scan position into buffer read addresses by accumulating a per-row base
// (no multiplier), realigns the returned colour index with the scan and maps it
// through a fixed 8-entry palette. One pixel per clock, 3-clock input-to-RGB latency.
// Ports:
//   clk_i : pixel clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : fetch bus (slave side), see frame_pixel_fetch_if
module frame_pixel_fetch #(
  parameter int unsigned FbW       = 450,
  parameter int unsigned FbH       = 450,
  parameter int unsigned X0        = 95,
  parameter int unsigned Y0        = 15,
  parameter logic [23:0] BorderRgb = 24'h202020
) (
  input logic                 clk_i,
  input logic                 rst_i,
  frame_pixel_fetch_if.slave  bus
);

  localparam logic [9:0]  XLo  = 10'(X0);
  localparam logic [9:0]  XHi  = 10'(X0 + FbW);
  localparam logic [9:0]  YLo  = 10'(Y0);
  localparam logic [9:0]  YHi  = 10'(Y0 + FbH);
  localparam logic [17:0] RowW = 18'(FbW);

  logic [17:0] row_base_q, row_base_d;
  logic [9:0]  y_prev_q;
  logic        synced_q;
  logic [17:0] read_address_q;
  logic        s0_win_q, s0_vis_q, s1_win_q, s1_vis_q;
  logic [23:0] rgb_q, rgb_d;

  logic        col_in, row_in, at_top, win_now;
  logic [9:0]  x_off;
  logic [17:0] addr_d;

  assign col_in = (bus.DrawX >= XLo) && (bus.DrawX < XHi);
  assign row_in = (bus.DrawY >= YLo) && (bus.DrawY < YHi);
  assign at_top = (bus.DrawY == YLo);
  // The top row counts as synced on the cycle it is first seen.
  assign win_now = col_in && row_in && (synced_q || at_top);
  assign x_off   = bus.DrawX - XLo;
  assign addr_d  = row_base_d + {8'd0, x_off};

  // Row base advances by one row width on the first sample of each new window row;
  // the top row restarts it at 0, which also recovers from any out-of-order rows.
  always_comb begin
    row_base_d = row_base_q;
    if (at_top) begin
      row_base_d = '0;
    end else if ((bus.DrawY != y_prev_q) && row_in) begin
      row_base_d = row_base_q + RowW;
    end
  end

  always_comb begin
    rgb_d = BorderRgb;
    if (!s1_vis_q) begin
      rgb_d = '0;
    end else if (s1_win_q) begin
      case (bus.fb_data)
        3'd0:    rgb_d = 24'h000000;
        3'd1:    rgb_d = 24'hFF0000;
        3'd2:    rgb_d = 24'h00FF00;
        3'd3:    rgb_d = 24'h0000FF;
        3'd4:    rgb_d = 24'hFFFF00;
        3'd5:    rgb_d = 24'h00FFFF;
        3'd6:    rgb_d = 24'hFF00FF;
        default: rgb_d = 24'hFFFFFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_base_q     <= '0;
      y_prev_q       <= '0;
      synced_q       <= 1'b0;
      read_address_q <= '0;
      s0_win_q       <= 1'b0;
      s0_vis_q       <= 1'b0;
      s1_win_q       <= 1'b0;
      s1_vis_q       <= 1'b0;
      rgb_q          <= '0;
    end else begin
      y_prev_q   <= bus.DrawY;
      row_base_q <= row_base_d;
      if (at_top) begin
        synced_q <= 1'b1;
      end
      // Hold the address outside the window so the buffer sees no needless toggles.
      if (win_now) begin
        read_address_q <= addr_d;
      end
      s0_win_q <= win_now;
      s0_vis_q <= bus.blank;
      s1_win_q <= s0_win_q;
      s1_vis_q <= s0_vis_q;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.VGA_R        = rgb_q[23:16];
  assign bus.VGA_G        = rgb_q[15:8];
  assign bus.VGA_B        = rgb_q[7:0];

endmodule

// File: tb/tb_frame_pixel_fetch.sv
// Scoreboard bench for frame_pixel_fetch: randomized sparse scan lines, a behavioural
// frame-buffer model and an arithmetic reference for address and colour.
module tb_frame_pixel_fetch;
  localparam int          FbW    = 450;
  localparam int          FbH    = 450;
  localparam int          X0     = 95;
  localparam int          Y0     = 15;
  localparam logic [23:0] Border = 24'h202020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_pixel_fetch_if bus ();

  frame_pixel_fetch dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int ecount = 0;

  always @(posedge clk) ecount <= ecount + 1;

  // Frame-buffer contents: a fixed scramble of the address.
  function automatic logic [2:0] mem_val(input logic [17:0] a);
    logic [17:0] t;
    t = a ^ (a >> 3) ^ (a >> 7);
    return t[2:0];
  endfunction

  function automatic logic [23:0] pal(input logic [2:0] i);
    case (i)
      3'd0: return 24'h000000;
      3'd1: return 24'hFF0000;
      3'd2: return 24'h00FF00;
      3'd3: return 24'h0000FF;
      3'd4: return 24'hFFFF00;
      3'd5: return 24'h00FFFF;
      3'd6: return 24'hFF00FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Registered-read buffer.
  always @(posedge clk) bus.fb_data <= mem_val(bus.read_address);

  typedef struct {
    int          tag;
    logic [23:0] val;
  } exp_t;

  exp_t addr_q[$];
  exp_t rgb_q[$];

  bit          m_synced = 1'b0;
  logic [17:0] m_addr   = '0;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Present one scan sample and queue what it should produce.
  task automatic pix(input int x, input int y, input bit b);
    bit          win;
    logic [23:0] rgb;
    exp_t        e;
    @(posedge clk);
    #1;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = b;
    if (y == Y0) m_synced = 1'b1;
    win = m_synced && x >= X0 && x < X0 + FbW && y >= Y0 && y < Y0 + FbH;
    if (win) m_addr = 18'((y - Y0) * FbW + (x - X0));
    if (!b)       rgb = 24'h0;
    else if (win) rgb = pal(mem_val(m_addr));
    else          rgb = Border;
    e.tag = ecount + 1;
    e.val = {6'd0, m_addr};
    addr_q.push_back(e);
    e.val = rgb;
    rgb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    addr_q.delete();
    rgb_q.delete();
    m_synced = 1'b0;
    m_addr   = '0;
    #1;
    check("async_reset_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 24'h0);
    check("async_reset_addr", {6'd0, bus.read_address}, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic scan_row(input int y, input bit reset_mid);
    int x;
    pix(X0, y, 1'b1);
    if (reset_mid) begin
      pix(300, y, 1'b1);
      do_reset();
    end
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) != 0) x = $urandom_range(X0 - 5, X0 + FbW + 4);
      else                           x = $urandom_range(0, 799);
      pix(x, y, $urandom_range(0, 7) != 0);
    end
    pix(X0 + FbW - 1, y, 1'b1);
    if (y % 5 == 0) pix(X0 - 1, y, 1'b1);
    pix(X0 + FbW, y, 1'b1);
  endtask

  // Monitor: compare queued expectations when the pipeline delivers them.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (addr_q.size() > 0 && addr_q[0].tag < ecount) begin
        e = addr_q.pop_front();
        check("addr_missed", 24'h0, 24'h1);
      end
      if (addr_q.size() > 0 && addr_q[0].tag == ecount) begin
        e = addr_q.pop_front();
        check("read_address", {6'd0, bus.read_address}, e.val);
      end
      while (rgb_q.size() > 0 && rgb_q[0].tag + 2 < ecount) begin
        e = rgb_q.pop_front();
        check("rgb_missed", 24'h0, 24'h1);
      end
      if (rgb_q.size() > 0 && rgb_q[0].tag + 2 == ecount) begin
        e = rgb_q.pop_front();
        check("rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, e.val);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    bus.DrawX = 10'd300;
    bus.DrawY = 10'd200;
    bus.blank = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, 24'h0);
    check("reset_addr", {6'd0, bus.read_address}, 24'h0);
    rst = 1'b0;

    // Released mid-frame inside the window: border only until the top row.
    for (int y = 200; y < 525; y++) scan_row(y, 1'b0);
    for (int y = 0; y < 525; y++) scan_row(y, 1'b0);
    for (int y = 0; y < 525; y++) scan_row(y, y == 300);
    for (int y = 0; y < 525; y++) scan_row(y, 1'b0);

    guard = 0;
    while ((addr_q.size() > 0 || rgb_q.size() > 0) && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (addr_q.size() != 0 || rgb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d left, expected 0/0", addr_q.size(), rgb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
